// File: rtl/pit_request_arbiter_if.sv
// -----------------------------------------------------------------------------
// pit_request_arbiter_if
//
// Groups the request, PIT-side and response signals of pit_request_arbiter.
//
// Modports:
//   slave  - the arbiter's view (accepts SPI/FIB requests, drives the PIT
//            request bus and the response bus, observes PIT results)
//   master - the environment's view (requesters, PIT, response consumer)
//
// Signal groups:
//   spi_req_valid/ready, spi_prefix[63:0], spi_length[5:0]   SPI interest side
//   fib_req_valid/ready, fib_prefix[63:0], fib_metadata[7:0] FIB data side
//   pit_spi_prefix, pit_length, pit_fib_prefix, pit_fib_metadata,
//   pit_out_bit, pit_prefix_ready                            request to PIT
//   pit_table_entry[10:0], pit_in_bit, pit_rejected,
//   pit_interest_packet                                      result from PIT
//   resp_valid, resp_src, resp_hit, resp_table_entry[10:0],
//   resp_interest, resp_timeout, busy                        response / status
// -----------------------------------------------------------------------------
interface pit_request_arbiter_if;
    // SPI request side
    logic        spi_req_valid;
    logic        spi_req_ready;
    logic [63:0] spi_prefix;
    logic [5:0]  spi_length;

    // FIB request side
    logic        fib_req_valid;
    logic        fib_req_ready;
    logic [63:0] fib_prefix;
    logic [7:0]  fib_metadata;

    // Request bus to the PIT
    logic [63:0] pit_spi_prefix;
    logic [5:0]  pit_length;
    logic [63:0] pit_fib_prefix;
    logic [7:0]  pit_fib_metadata;
    logic        pit_out_bit;
    logic        pit_prefix_ready;

    // Result from the PIT
    logic [10:0] pit_table_entry;
    logic        pit_in_bit;
    logic        pit_rejected;
    logic        pit_interest_packet;

    // Response to the originating requester
    logic        resp_valid;
    logic        resp_src;
    logic        resp_hit;
    logic [10:0] resp_table_entry;
    logic        resp_interest;
    logic        resp_timeout;
    logic        busy;

    modport slave (
        input  spi_req_valid, spi_prefix, spi_length,
        output spi_req_ready,
        input  fib_req_valid, fib_prefix, fib_metadata,
        output fib_req_ready,
        output pit_spi_prefix, pit_length, pit_fib_prefix, pit_fib_metadata,
        output pit_out_bit, pit_prefix_ready,
        input  pit_table_entry, pit_in_bit, pit_rejected, pit_interest_packet,
        output resp_valid, resp_src, resp_hit, resp_table_entry,
        output resp_interest, resp_timeout, busy
    );

    modport master (
        output spi_req_valid, spi_prefix, spi_length,
        input  spi_req_ready,
        output fib_req_valid, fib_prefix, fib_metadata,
        input  fib_req_ready,
        input  pit_spi_prefix, pit_length, pit_fib_prefix, pit_fib_metadata,
        input  pit_out_bit, pit_prefix_ready,
        output pit_table_entry, pit_in_bit, pit_rejected, pit_interest_packet,
        input  resp_valid, resp_src, resp_hit, resp_table_entry,
        input  resp_interest, resp_timeout, busy
    );
endinterface

// File: rtl/pit_request_arbiter.sv
// -----------------------------------------------------------------------------
// pit_request_arbiter
//
// Front-end controller for the PIT hash table. Serialises SPI interest
// requests and FIB data-return requests onto the PIT's single request
// interface, waits for the PIT result (or a timeout) and returns it to the
// originating requester as a one-cycle response pulse. Round-robin on ties.
//
// Parameters:
//   MIN_WAIT - strobe-high WAIT cycles before pit_in_bit is trusted
//   TIMEOUT  - WAIT cycle count at which the transaction is forced to end
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active-high
//   bus  - pit_request_arbiter_if.slave (requests, PIT bus, responses)
// -----------------------------------------------------------------------------
module pit_request_arbiter #(
    parameter int MIN_WAIT = 2,
    parameter int TIMEOUT  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    pit_request_arbiter_if.slave        bus
);

    localparam int              CW         = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   MIN_WAIT_C = CW'(MIN_WAIT);
    localparam logic [CW-1:0]   TIMEOUT_C  = CW'(TIMEOUT);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_RESP  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    localparam logic SRC_SPI = 1'b0;
    localparam logic SRC_FIB = 1'b1;

    logic [2:0]    state;
    logic          last_grant;
    logic          src_q;
    logic          rej_q;
    logic [CW-1:0] wait_cnt;

    logic          grant_spi;
    logic          grant_fib;
    logic          done_hit;
    logic          done_rej;
    logic          done_to;

    // Grant is combinational so ready can be asserted in the same IDLE cycle
    // the request is seen; only the granted side ever sees ready.
    always_comb begin
        grant_spi = 1'b0;
        grant_fib = 1'b0;
        if (state == ST_IDLE) begin
            if (bus.spi_req_valid && bus.fib_req_valid) begin
                grant_spi = (last_grant == SRC_FIB);
                grant_fib = (last_grant == SRC_SPI);
            end else begin
                grant_spi = bus.spi_req_valid;
                grant_fib = bus.fib_req_valid;
            end
        end
    end

    assign bus.spi_req_ready = grant_spi;
    assign bus.fib_req_ready = grant_fib;

    // Completion terms, meaningful only in WAIT. pit_in_bit is masked for the
    // first MIN_WAIT-1 cycles because the PIT leaves it high from the previous
    // transaction; pit_rejected is sticky in the PIT, so only its rising edge
    // counts.
    assign done_hit = bus.pit_in_bit && (wait_cnt >= MIN_WAIT_C);
    assign done_rej = bus.pit_rejected && !rej_q;
    assign done_to  = (wait_cnt == TIMEOUT_C);

    assign bus.resp_valid = (state == ST_RESP);
    assign bus.busy       = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= ST_IDLE;
            last_grant           <= SRC_FIB;
            src_q                <= SRC_SPI;
            rej_q                <= 1'b0;
            wait_cnt             <= '0;
            bus.pit_spi_prefix   <= '0;
            bus.pit_length       <= '0;
            bus.pit_fib_prefix   <= '0;
            bus.pit_fib_metadata <= '0;
            bus.pit_out_bit      <= 1'b0;
            bus.pit_prefix_ready <= 1'b0;
            bus.resp_src         <= 1'b0;
            bus.resp_hit         <= 1'b0;
            bus.resp_table_entry <= '0;
            bus.resp_interest    <= 1'b0;
            bus.resp_timeout     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // The strobe is registered on the accept edge so it is
                    // already high throughout ISSUE.
                    if (grant_spi) begin
                        bus.pit_spi_prefix <= bus.spi_prefix;
                        bus.pit_length     <= bus.spi_length;
                        bus.pit_out_bit    <= 1'b1;
                        src_q              <= SRC_SPI;
                        last_grant         <= SRC_SPI;
                        state              <= ST_ISSUE;
                    end else if (grant_fib) begin
                        bus.pit_fib_prefix   <= bus.fib_prefix;
                        bus.pit_fib_metadata <= bus.fib_metadata;
                        bus.pit_prefix_ready <= 1'b1;
                        src_q                <= SRC_FIB;
                        last_grant           <= SRC_FIB;
                        state                <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    wait_cnt <= CW'(1);
                    state    <= ST_WAIT;
                end

                ST_WAIT: begin
                    // rej_q only follows the flag during WAIT so that a flag
                    // still stuck from an earlier rejection is not re-detected,
                    // while a fresh rise during ISSUE is still caught.
                    rej_q <= bus.pit_rejected;
                    if (done_hit || done_rej || done_to) begin
                        bus.pit_out_bit      <= 1'b0;
                        bus.pit_prefix_ready <= 1'b0;
                        bus.resp_src         <= src_q;
                        bus.resp_hit         <= done_hit;
                        bus.resp_timeout     <= !done_hit && !done_rej;
                        bus.resp_table_entry <= bus.pit_table_entry;
                        bus.resp_interest    <= bus.pit_interest_packet;
                        state                <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_RESP: begin
                    state <= ST_GAP;
                end

                ST_GAP: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
